// File: rtl/miner_job_ctrl.sv
// Job sequencer for one sha256 hashing core: a one-deep pending work slot, a
// core-facing load/start/monitor FSM, and a first-word fall-through golden-nonce FIFO.
module miner_job_ctrl #(
    parameter int          RES_DEPTH   = 4,
    parameter int          BUSY_WAIT   = 8,
    parameter logic [31:0] RUN_TIMEOUT = 32'hFFFF_FFFF,
    parameter bit          PREEMPT     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data2,
    input  logic         work_nonce_half,
    output logic [255:0] miner_midstate,
    output logic [95:0]  miner_data2,
    output logic         miner_nonce_start,
    output logic         miner_start,
    input  logic         miner_busy,
    input  logic         got_ticket,
    input  logic [31:0]  golden_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic         job_active,
    output logic [3:0]   status,
    output logic [15:0]  jobs_done,
    output logic [2:0]   fsm_state
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t state, state_nx;

    logic         pend_full;
    logic [255:0] pend_midstate;
    logic [95:0]  pend_data2;
    logic         pend_half;
    logic         got_ticket_q;
    logic         ticket_seen;
    logic [WW-1:0] wait_cnt;
    logic [31:0]  run_cnt;
    logic [31:0]  fifo_mem [RES_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;

    logic load, busy_err, job_done, exhausted, timeout;
    logic tick_rise, push, pop, fifo_full, push_ok, overflow;

    // Handshakes are strict valid/ready: a transfer happens on a clock edge where
    // both are high; valid never depends on ready on either port.
    assign work_ready = !pend_full;
    assign res_valid  = (fifo_cnt != '0);
    assign res_nonce  = fifo_mem[rd_ptr];
    assign pop        = res_valid && res_ready;
    assign fifo_full  = (fifo_cnt == CW'(RES_DEPTH));

    assign tick_rise = (state == S_RUN) && got_ticket && !got_ticket_q;
    assign push      = tick_rise;
    assign push_ok   = push && (!fifo_full || pop);
    assign overflow  = push && fifo_full && !pop;

    assign miner_start = (state == S_START);
    assign job_active  = (state != S_IDLE);
    assign fsm_state   = state;

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        busy_err  = 1'b0;
        job_done  = 1'b0;
        exhausted = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE:  if (pend_full) state_nx = S_LOAD;
            S_LOAD: begin
                load     = 1'b1;
                state_nx = S_START;
            end
            S_START: state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (miner_busy) begin
                    state_nx = S_RUN;
                end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
                    busy_err = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                // Preempt beats completion: an aborted job is not counted as done.
                if (PREEMPT && pend_full) begin
                    state_nx = S_LOAD;
                end else if (!miner_busy) begin
                    job_done  = 1'b1;
                    exhausted = !(ticket_seen || tick_rise);
                    state_nx  = S_IDLE;
                end else if ((RUN_TIMEOUT != 32'd0) && (run_cnt == RUN_TIMEOUT)) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full     <= 1'b0;
            pend_midstate <= '0;
            pend_data2    <= '0;
            pend_half     <= 1'b0;
        end else if (load) begin
            pend_full <= 1'b0;
        end else if (work_valid && work_ready) begin
            pend_full     <= 1'b1;
            pend_midstate <= work_midstate;
            pend_data2    <= work_data2;
            pend_half     <= work_nonce_half;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miner_midstate    <= '0;
            miner_data2       <= '0;
            miner_nonce_start <= 1'b0;
        end else if (load) begin
            miner_midstate    <= pend_midstate;
            miner_data2       <= pend_data2;
            miner_nonce_start <= pend_half;
        end
    end

    // run_cnt holds the 1-based index of the current RUN cycle and saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            got_ticket_q <= 1'b0;
            ticket_seen  <= 1'b0;
            wait_cnt     <= '0;
            run_cnt      <= '0;
        end else if (state == S_START) begin
            got_ticket_q <= 1'b0;
            ticket_seen  <= 1'b0;
            wait_cnt     <= '0;
            run_cnt      <= '0;
        end else begin
            got_ticket_q <= got_ticket;
            if (tick_rise) ticket_seen <= 1'b1;
            if (state == S_WAIT_BUSY && !miner_busy) wait_cnt <= wait_cnt + WW'(1);
            if (state == S_WAIT_BUSY && miner_busy) run_cnt <= 32'd1;
            else if (state == S_RUN && run_cnt != 32'hFFFF_FFFF) run_cnt <= run_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status    <= '0;
            jobs_done <= '0;
        end else begin
            status    <= status | {exhausted, timeout, busy_err, overflow};
            if (job_done) jobs_done <= jobs_done + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= golden_nonce;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed bench for miner_job_ctrl: start latency, ticket capture, busy error,
// preemption, FIFO overflow/drain, exhausted and run timeout.
module tb_miner_job_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data2;
    logic         work_nonce_half;
    logic [255:0] miner_midstate;
    logic [95:0]  miner_data2;
    logic         miner_nonce_start;
    logic         miner_start;
    logic         miner_busy;
    logic         got_ticket;
    logic [31:0]  golden_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;
    logic         job_active;
    logic [3:0]   status;
    logic [15:0]  jobs_done;
    logic [2:0]   fsm_state;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] MS1 = {8{32'h1111_1111}};
    localparam logic [95:0]  D21 = {3{32'h2222_2222}};
    localparam logic [255:0] MS2 = {8{32'h3333_3333}};
    localparam logic [95:0]  D22 = {3{32'h4444_4444}};
    localparam logic [255:0] MS3 = {8{32'h5555_5555}};
    localparam logic [95:0]  D23 = {3{32'h6666_6666}};
    localparam logic [255:0] MS4 = {8{32'h7777_7777}};
    localparam logic [95:0]  D24 = {3{32'h8888_8888}};

    logic [31:0] nonces [5];

    miner_job_ctrl #(
        .RES_DEPTH(4), .BUSY_WAIT(8), .RUN_TIMEOUT(32'd20), .PREEMPT(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_data2(work_data2),
        .work_nonce_half(work_nonce_half),
        .miner_midstate(miner_midstate), .miner_data2(miner_data2),
        .miner_nonce_start(miner_nonce_start), .miner_start(miner_start),
        .miner_busy(miner_busy), .got_ticket(got_ticket), .golden_nonce(golden_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .job_active(job_active), .status(status), .jobs_done(jobs_done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a job; returns just after the edge where miner_start should be high.
    task automatic offer(input logic [255:0] ms, input logic [95:0] d2, input logic half);
        work_valid      = 1'b1;
        work_midstate   = ms;
        work_data2      = d2;
        work_nonce_half = half;
        step();
        work_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        nonces[0] = 32'hA000_0001; nonces[1] = 32'hA000_0002; nonces[2] = 32'hA000_0003;
        nonces[3] = 32'hA000_0004; nonces[4] = 32'hA000_0005;
        rst = 1'b1; work_valid = 1'b0; work_midstate = '0; work_data2 = '0;
        work_nonce_half = 1'b0; miner_busy = 1'b0; got_ticket = 1'b0;
        golden_nonce = '0; res_ready = 1'b0;
        step(); step();

        chk("rst_work_ready", work_ready, 1);
        chk("rst_miner_start", miner_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_job_active", job_active, 0);
        chk("rst_midstate", miner_midstate, 0);
        chk("rst_data2", miner_data2, 0);
        chk("rst_nonce_start", miner_nonce_start, 0);
        chk("rst_status", status, 0);
        chk("rst_jobs_done", jobs_done, 0);
        rst = 1'b0;
        step();

        // Job 1: accept, start latency, ticket, normal completion.
        work_valid = 1'b1; work_midstate = MS1; work_data2 = D21; work_nonce_half = 1'b1;
        step();
        work_valid = 1'b0;
        chk("j1_ready_low", work_ready, 0);
        chk("j1_start_e0", miner_start, 0);
        step();
        chk("j1_start_e1", miner_start, 0);
        step();
        chk("j1_start_e2", miner_start, 1);
        chk("j1_midstate", miner_midstate, MS1);
        chk("j1_data2", miner_data2, D21);
        chk("j1_half", miner_nonce_start, 1);
        chk("j1_active", job_active, 1);
        chk("j1_ready_back", work_ready, 1);
        step();
        chk("j1_start_pulse", miner_start, 0);
        miner_busy = 1'b1;
        step();
        chk("j1_in_run", fsm_state, 3'd4);
        got_ticket = 1'b1; golden_nonce = 32'h8000_1234;
        step();
        chk("j1_res_valid", res_valid, 1);
        chk("j1_res_nonce", res_nonce, 32'h8000_1234);
        miner_busy = 1'b0;
        step();
        got_ticket = 1'b0;
        chk("j1_jobs_done", jobs_done, 1);
        chk("j1_status", status, 0);
        chk("j1_idle", job_active, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("j1_drained", res_valid, 0);

        // Job 2: core never goes busy.
        offer(MS2, D22, 1'b0);
        chk("j2_start", miner_start, 1);
        chk("j2_midstate", miner_midstate, MS2);
        chk("j2_half", miner_nonce_start, 0);
        for (int i = 0; i < 8; i++) step();
        chk("j2_before_err", status, 4'b0000);
        chk("j2_still_active", job_active, 1);
        step();
        chk("j2_busy_err", status, 4'b0010);
        chk("j2_idle", fsm_state, 3'd0);
        chk("j2_no_push", res_valid, 0);
        chk("j2_jobs_done", jobs_done, 1);

        // Job 3 preempted by job 4 while running.
        offer(MS3, D23, 1'b1);
        chk("j3_start", miner_start, 1);
        step();
        miner_busy = 1'b1;
        step();
        chk("j3_in_run", fsm_state, 3'd4);
        work_valid = 1'b1; work_midstate = MS4; work_data2 = D24; work_nonce_half = 1'b0;
        step();
        work_valid = 1'b0;
        chk("j4_accepted", work_ready, 0);
        step();
        chk("j4_load", fsm_state, 3'd1);
        chk("j3_regs_stable", miner_midstate, MS3);
        step();
        chk("j4_start", miner_start, 1);
        chk("j4_midstate", miner_midstate, MS4);
        chk("j4_data2", miner_data2, D24);
        chk("j4_half", miner_nonce_start, 0);
        chk("j4_jobs_unchanged", jobs_done, 1);
        step();
        step();
        chk("j4_in_run", fsm_state, 3'd4);

        // Five tickets into a four-deep FIFO with no consumer.
        for (int i = 0; i < 5; i++) begin
            got_ticket = 1'b1; golden_nonce = nonces[i];
            step();
            got_ticket = 1'b0;
            step();
        end
        chk("ovf_status", status, 4'b0011);
        chk("ovf_head", res_nonce, nonces[0]);
        miner_busy = 1'b0;
        step();
        chk("j4_jobs_done", jobs_done, 2);
        chk("j4_status", status, 4'b0011);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_valid%0d", i), res_valid, 1);
            chk($sformatf("drain_nonce%0d", i), res_nonce, nonces[i]);
            step();
        end
        res_ready = 1'b0;
        chk("drain_empty", res_valid, 0);

        // Job 5: busy falls without a ticket.
        offer(MS1, D22, 1'b0);
        step();
        miner_busy = 1'b1;
        step();
        miner_busy = 1'b0;
        step();
        chk("j5_exhausted", status, 4'b1011);
        chk("j5_jobs_done", jobs_done, 3);
        chk("j5_idle", job_active, 0);

        // Job 6: busy held high until the run timeout.
        offer(MS2, D21, 1'b1);
        step();
        miner_busy = 1'b1;
        step();
        for (int i = 0; i < 19; i++) step();
        chk("j6_before_timeout", status, 4'b1011);
        chk("j6_still_run", fsm_state, 3'd4);
        step();
        chk("j6_timeout", status, 4'b1111);
        chk("j6_idle", job_active, 0);
        chk("j6_jobs_done", jobs_done, 3);
        miner_busy = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/miner_job_ctrl.md
Name: miner_job_ctrl

Overview:
Job sequencer in front of one sha256_top hashing core.
- Accepts work packets (midstate, data2, nonce half) from the host-command side through a valid/ready handshake, with one pending slot.
- Loads the core's work registers and pulses start_mining; monitors miner_busy and got_ticket.
- Queues golden nonces in a small result FIFO for the reply path and reports job status.

Parameters:
RES_DEPTH, 4, result FIFO depth; power of two, 2..16.
BUSY_WAIT, 8, max cycles from miner_start until miner_busy must be high.
RUN_TIMEOUT, 32'hFFFF_FFFF, max cycles in RUN before a forced abort; 0 disables.
PREEMPT, 1, 1 = a pending job aborts the running job; 0 = pending job waits for completion.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset, asynchronous, active-high.
work_valid  in  1  work packet valid.
work_ready  out  1  pending slot empty.
work_midstate  in  256  job midstate.
work_data2  in  96  job tail data.
work_nonce_half  in  1  nonce MSB for this job.
miner_midstate  out  256  to core midstate; registered.
miner_data2  out  96  to core data2; registered.
miner_nonce_start  out  1  to core nonce_start.
miner_start  out  1  to core start_mining; one-cycle pulse.
miner_busy  in  1  from core.
got_ticket  in  1  from core; sticky until the next start.
golden_nonce  in  32  from core.
res_valid  out  1  result FIFO not empty.
res_ready  in  1  result consumer ready.
res_nonce  out  32  FIFO head.
job_active  out  1  FSM not in IDLE.
status  out  4  sticky flags: [0] overflow, [1] busy_err, [2] timeout, [3] exhausted.
jobs_done  out  16  completed-job counter; wraps.

Behaviour:
- Reset (async assert, clocked deassert): FSM IDLE; pending slot empty; active regs, FIFO, status and jobs_done cleared.
- Output values during reset: work_ready=1, miner_start=0, res_valid=0, job_active=0, all miner_* outputs 0.
- Pending slot:
  - Fills on work_valid & work_ready.
  - work_ready = !pend_full.
  - Empties when its contents are copied to the active regs.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, RUN.
- IDLE: if pend_full -> LOAD.
- LOAD: copy pending slot to miner_midstate/miner_data2/miner_nonce_start; clear pending; -> START.
- START:
  - miner_start=1 for exactly this cycle.
  - Clear ticket-edge history and run counter; -> WAIT_BUSY.
- Latency: miner_start is high exactly 2 cycles after the accepting edge (IDLE case).
- WAIT_BUSY:
  - miner_busy=1 -> RUN.
  - BUSY_WAIT cycles elapse with miner_busy=0 -> set status[1], -> IDLE.
- RUN:
  - Rising edge of got_ticket (got_ticket & !got_ticket_q): push golden_nonce into the FIFO in that same cycle.
  - miner_busy=0: increment jobs_done; set status[3] if no ticket was seen this job; -> IDLE.
  - PREEMPT=1 and pend_full: -> LOAD (abort). jobs_done is not incremented.
  - RUN_TIMEOUT!=0 and run counter == RUN_TIMEOUT: set status[2], -> IDLE.
  - Priority when several occur together: ticket push first (always done), then preempt, then busy-fall, then timeout.
- Active regs are stable from LOAD until the next LOAD; the core sees constant inputs for the whole job.
- Result FIFO (RES_DEPTH entries, first-word fall-through):
  - Pop on res_valid & res_ready.
  - Push while full: drop the new nonce and set status[0]; existing entries are unchanged.
  - Push and pop in the same cycle while full: both succeed.
- status bits are cleared only by rst.
- rst mid-job: everything returns to reset values immediately; the core is resynchronised by the next miner_start.
- Wrap-around: jobs_done FFFF -> 0000; run counter saturates.

Test Plan:
- After reset, accept job (ms=256'h11.., d2=96'h22.., half=1) at edge E0 -> miner_start high for one cycle at E2; miner_midstate/miner_data2/miner_nonce_start match the job; job_active=1.
- Model core raises miner_busy 2 cycles after start, then got_ticket with golden_nonce=32'h8000_1234, then drops busy -> res_nonce=32'h8000_1234 with res_valid=1; jobs_done=1; status=0.
- Core never raises busy -> after BUSY_WAIT=8 cycles status[1]=1, FSM IDLE, no FIFO push.
- PREEMPT=1, second job offered during RUN -> accepted next edge; miner_start re-pulses 2 cycles later with the new data; jobs_done unchanged.
- 5 tickets with res_ready=0 and RES_DEPTH=4 -> FIFO holds the first 4 nonces in order; status[0]=1; draining yields exactly those 4.
- busy falls with no ticket -> status[3]=1, jobs_done+1; RUN_TIMEOUT=20 with busy held high -> status[2]=1 at cycle 20 of RUN.
